// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command receiver: frame geometry, field
// positions, command codes and the receive FSM encoding.
package spi_cmd_pkg;

    localparam int LEN_SPI      = 32;
    localparam int SPI_CODE_LEN = 6;
    localparam int SPI_ADDR_LEN = 10;
    localparam int SPI_DATA_LEN = 16;

    localparam int CODE_MSB = 31;
    localparam int CODE_LSB = 26;
    localparam int ADDR_MSB = 25;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    // Bit counter must hold LEN_SPI+1 so that over-long frames stay distinguishable.
    localparam int IDX_W = $clog2(LEN_SPI);
    localparam int CNT_W = $clog2(LEN_SPI + 2);

    localparam logic [SPI_CODE_LEN-1:0] CMD_WR_REC    = 6'd4;
    localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST   = 6'd7;
    localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_UNRST = 6'd8;
    localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ADC    = 6'd19;
    localparam logic [SPI_CODE_LEN-1:0] CMD_WR_CHEM   = 6'd20;
    localparam logic [SPI_CODE_LEN-1:0] CMD_LAST      = 6'd24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one pad input, with optional rise/fall detect
// taken from the last two synchronized samples.
module spi_in_sync #(
    parameter int   STAGES   = 2,
    parameter logic RST_VAL  = 1'b0,
    parameter bit   EDGE_DET = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {STAGES{RST_VAL}};
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic prev_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) prev_q <= RST_VAL;
                else       prev_q <= q_o;
            end
            assign rise_o = q_o & ~prev_q;
            assign fall_o = ~q_o & prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_cmd_rx.sv
// SPI slave command receiver: shifts in 32-bit LSB-first frames, shifts the
// captured response word out on miso, and strobes the decoded command.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a cs_n fall; miso low, busy low
//   ST_SHIFT | frame in progress: sample mosi on sck rise, drive miso on fall
//   ST_CHECK | one cycle after cs_n rise: strobe cmd_valid or frame_err
module spi_slave_cmd_rx
    import spi_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_50M,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic                    miso,
    input  logic [LEN_SPI-1:0]      rsp_data,
    output logic                    cmd_valid,
    output logic [SPI_CODE_LEN-1:0] cmd_code,
    output logic [SPI_ADDR_LEN-1:0] cmd_addr,
    output logic [SPI_DATA_LEN-1:0] cmd_data,
    output logic                    frame_err,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN_SPI);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN_SPI + 1);
    localparam logic [3:0]       FLUSH   = 4'(SYNC_STAGES + 1);

    logic sck_lvl_unused, sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync;
    logic [1:0] mosi_edge_unused;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_DET(1'b1)) u_sync_sck (
        .clk_i(clk_50M), .rst_i(rst), .d_i(sck),
        .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_DET(1'b1)) u_sync_cs (
        .clk_i(clk_50M), .rst_i(rst), .d_i(cs_n),
        .q_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_mosi (
        .clk_i(clk_50M), .rst_i(rst), .d_i(mosi),
        .q_o(mosi_sync), .rise_o(mosi_edge_unused[0]), .fall_o(mosi_edge_unused[1])
    );

    rx_state_e               state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [CNT_W-1:0]        bit_cnt_d;
    logic [LEN_SPI-1:0]      rx_sr_q;
    logic [LEN_SPI-1:0]      rsp_sr_q;
    logic                    miso_q;
    logic                    cmd_valid_q;
    logic                    frame_err_q;
    logic [SPI_CODE_LEN-1:0] cmd_code_q;
    logic [SPI_ADDR_LEN-1:0] cmd_addr_q;
    logic [SPI_DATA_LEN-1:0] cmd_data_q;
    logic                    busy_q;
    logic [3:0]              flush_q;
    logic                    arm_q;

    assign bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;

    // The cs_n synchronizer is preset high, so a reset released mid-frame would
    // look like a fresh cs_n fall. Only arm once the pipeline holds real samples
    // and cs_n has been seen high, which drops any frame in flight at release.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            rsp_sr_q    <= '0;
            miso_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            flush_q     <= '0;
            arm_q       <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (flush_q != FLUSH) flush_q <= flush_q + 1'b1;
            else if (cs_sync)     arm_q   <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall && arm_q) begin
                        state_q   <= ST_SHIFT;
                        rsp_sr_q  <= rsp_data;
                        miso_q    <= rsp_data[0];
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state_q <= ST_CHECK;
                    end else if (sck_rise) begin
                        if (bit_cnt_q < CNT_LEN) rx_sr_q[bit_cnt_q[IDX_W-1:0]] <= mosi_sync;
                        bit_cnt_q <= bit_cnt_d;
                    end else if (sck_fall) begin
                        miso_q <= (bit_cnt_q < CNT_LEN) ? rsp_sr_q[bit_cnt_q[IDX_W-1:0]] : 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (bit_cnt_q == CNT_LEN) begin
                        cmd_code_q  <= rx_sr_q[CODE_MSB:CODE_LSB];
                        cmd_addr_q  <= rx_sr_q[ADDR_MSB:ADDR_LSB];
                        cmd_data_q  <= rx_sr_q[DATA_MSB:DATA_LSB];
                        cmd_valid_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso      = miso_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_cmd_rx.sv
// Directed bench for spi_slave_cmd_rx: bit-banged SPI master with
// hand-computed expected command fields, strobe timing and miso words.
module tb_spi_slave_cmd_rx;

    logic        clk_50M = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b1;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [31:0] rsp_data = 32'h0;
    logic        cmd_valid;
    logic [5:0]  cmd_code;
    logic [9:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_err    = 0;

    always #10 clk_50M = ~clk_50M;

    spi_slave_cmd_rx dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .rsp_data (rsp_data),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always @(negedge clk_50M) begin
        if (cmd_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Master sets mosi on sck fall and samples miso just before sck rise.
    // cs_n rise is aligned 1 ns after a clk edge so strobe latency is exact.
    task automatic send_frame(input logic [63:0] frame, input int nbits,
                              input int rst_at, input int chg_at,
                              output logic [31:0] miso_word, output logic pre,
                              output logic v4, output logic e4, output logic post);
        miso_word = '0;
        cs_n = 1'b0;
        #500;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = frame[i];
            #500;
            if (i < 32) miso_word[i] = miso;
            sck = 1'b1;
            if (i == 16 && rst_at < 0) chk("busy_mid", busy, 1'b1);
            #500;
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_miso", miso, 1'b0);
                #99;
                rst = 1'b0;
            end
            if (i == chg_at) rsp_data = 32'hFFFF_FFFF;
        end
        #500;
        @(posedge clk_50M) #1 cs_n = 1'b1;
        repeat (3) @(posedge clk_50M);
        #1 pre = cmd_valid | frame_err;
        @(posedge clk_50M) #1;
        v4 = cmd_valid;
        e4 = frame_err;
        @(posedge clk_50M) #1 post = cmd_valid | frame_err;
        mosi = 1'b0;
        #1000;
    endtask

    logic [31:0] mw;
    logic        pre, v4, e4, post;
    int          base_v, base_e;

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_err",   frame_err, 1'b0);
        chk("rst_busy0", busy, 1'b0);
        chk("rst_miso0", miso, 1'b0);
        chk("rst_code",  cmd_code, 6'd0);
        chk("rst_addr",  cmd_addr, 10'd0);
        chk("rst_data",  cmd_data, 16'd0);
        repeat (3) @(posedge clk_50M);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk_50M);
        #1;

        // code 8 / addr 4 / data 0
        send_frame(64'h2004_0000, 32, -1, -1, mw, pre, v4, e4, post);
        chk("f1_pre", pre, 1'b0);
        chk("f1_valid_lat4", v4, 1'b1);
        chk("f1_err", e4, 1'b0);
        chk("f1_post", post, 1'b0);
        chk("f1_code", cmd_code, 6'd8);
        chk("f1_addr", cmd_addr, 10'd4);
        chk("f1_data", cmd_data, 16'h0000);
        chk("f1_busy_end", busy, 1'b0);
        chk("f1_miso_end", miso, 1'b0);

        // response word shifted out; rsp_data change mid-frame must not leak
        rsp_data = 32'hA5A5_0F0F;
        send_frame(64'h1009_003A, 32, -1, 10, mw, pre, v4, e4, post);
        chk("f2_valid", v4, 1'b1);
        chk("f2_code", cmd_code, 6'd4);
        chk("f2_addr", cmd_addr, 10'd9);
        chk("f2_data", cmd_data, 16'h003A);
        chk("f2_miso_word", mw, 32'hA5A5_0F0F);

        // next frame captures the new response word
        rsp_data = 32'h1234_5678;
        send_frame(64'h2004_0000, 32, -1, -1, mw, pre, v4, e4, post);
        chk("f3_miso_word", mw, 32'h1234_5678);
        chk("f3_code", cmd_code, 6'd8);

        // short and long frames
        base_v = n_valid;
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 31, -1, -1, mw, pre, v4, e4, post);
        chk("short_err", e4, 1'b1);
        chk("short_valid", v4, 1'b0);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 33, -1, -1, mw, pre, v4, e4, post);
        chk("long_err", e4, 1'b1);
        chk("long_valid", v4, 1'b0);
        chk("bad_no_valid", n_valid - base_v, 0);
        chk("bad_hold_code", cmd_code, 6'd8);
        chk("bad_hold_addr", cmd_addr, 10'd4);

        // zero-bit frame
        send_frame(64'h0, 0, -1, -1, mw, pre, v4, e4, post);
        chk("zero_err", e4, 1'b1);

        // three back-to-back frames
        base_v = n_valid;
        base_e = n_err;
        for (int k = 0; k < 3; k++) begin
            send_frame(64'h4C0B_0000, 32, -1, -1, mw, pre, v4, e4, post);
            chk("b2b_valid", v4, 1'b1);
            chk("b2b_code", cmd_code, 6'd19);
            chk("b2b_addr", cmd_addr, 10'd11);
        end
        chk("b2b_nvalid", n_valid - base_v, 3);
        chk("b2b_nerr", n_err - base_e, 0);

        // reset after bit 12: frame dropped silently, next frame accepted
        base_v = n_valid;
        base_e = n_err;
        send_frame(64'h4C0B_0000, 32, 12, -1, mw, pre, v4, e4, post);
        chk("rstf_valid", v4, 1'b0);
        chk("rstf_err", e4, 1'b0);
        chk("rstf_nstrobe", (n_valid - base_v) + (n_err - base_e), 0);
        chk("rstf_code", cmd_code, 6'd0);
        chk("rstf_busy", busy, 1'b0);
        send_frame(64'h3000_0000, 32, -1, -1, mw, pre, v4, e4, post);
        chk("after_rst_valid", v4, 1'b1);
        chk("after_rst_code", cmd_code, 6'd12);

        // sck activity with cs_n high, then a normal frame
        base_v = n_valid;
        base_e = n_err;
        for (int k = 0; k < 10; k++) begin
            sck = 1'b0;
            mosi = k[0];
            #500;
            sck = 1'b1;
            #500;
        end
        mosi = 1'b0;
        chk("idle_sck_nstrobe", (n_valid - base_v) + (n_err - base_e), 0);
        chk("idle_sck_busy", busy, 1'b0);
        send_frame(64'h1009_003A, 32, -1, -1, mw, pre, v4, e4, post);
        chk("post_idle_valid", v4, 1'b1);
        chk("post_idle_code", cmd_code, 6'd4);
        chk("post_idle_data", cmd_data, 16'h003A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
